// File: rtl/sample_fetch_if.sv
// Single-word read port between sample_fetch (master) and the cellular RAM controller (slave).
interface sample_fetch_if #(
  parameter int unsigned ADDR_W = 26
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [15:0]       rd_data;

  modport master (output rd_req, rd_addr, input rd_ack, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/sample_fetch.sv
// Streams a sample buffer from cellular RAM through a small FIFO, one sample per rate tick.
// Optional 8-bit PWM audio output is enabled by defining SAMPLE_FETCH_PWM_EN.
module sample_fetch #(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_DIV    = 2268
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  sample_fetch_if.master    ram,
  output logic [15:0]       sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              underrun,
  output logic              pwm_out
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, ABORT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr, remaining, base_l, len_l;
  logic              loop_l;
  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DIV_W-1:0]  div;
  logic              tick, push, pop, go_idle;

  assign busy = (state != IDLE);

  // Every path back to IDLE funnels through go_idle so the FIFO flush lives in one place.
  always_comb begin
    tick    = busy && (div == DIV_W'(CLK_DIV - 1));
    pop     = tick && (count != '0);
    push    = (state == WAIT) && ram.rd_ack && !stop;
    go_idle = 1'b0;
    case (state)
      REQ:     go_idle = stop;
      WAIT:    go_idle = stop && ram.rd_ack;
      DRAIN:   go_idle = stop || (count == '0) || ((count == CNT_W'(1)) && pop);
      ABORT:   go_idle = ram.rd_ack;
      default: go_idle = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ram.rd_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ram.rd_req   <= 1'b0;
      ram.rd_addr  <= '0;
      addr         <= '0;
      remaining    <= '0;
      base_l       <= '0;
      len_l        <= '0;
      loop_l       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      div          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= pop;
      if (pop) sample <= mem[rd_ptr];
      if (tick && (count == '0) && ((state == REQ) || (state == WAIT))) underrun <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      div <= (!busy || tick) ? '0 : div + 1'b1;

      if (go_idle) begin
        state      <= IDLE;
        ram.rd_req <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        div        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (length != '0)) begin
              addr      <= base_addr;
              remaining <= length;
              base_l    <= base_addr;
              len_l     <= length;
              loop_l    <= loop;
              underrun  <= 1'b0;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              count     <= '0;
              state     <= REQ;
            end
          end
          REQ: begin
            if (count < CNT_W'(FIFO_DEPTH)) begin
              ram.rd_req  <= 1'b1;
              ram.rd_addr <= addr;
              state       <= WAIT;
            end
          end
          WAIT: begin
            if (stop) begin
              state <= ABORT;
            end else if (ram.rd_ack) begin
              ram.rd_req <= 1'b0;
              if (remaining == ADDR_W'(1)) begin
                if (loop_l) begin
                  addr      <= base_l;
                  remaining <= len_l;
                  state     <= REQ;
                end else begin
                  state <= DRAIN;
                end
              end else begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
                state     <= REQ;
              end
            end
          end
          DRAIN:   state <= DRAIN;
          ABORT:   state <= ABORT;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SAMPLE_FETCH_PWM_EN
  logic [7:0] pwm_cnt;
  logic [7:0] level;

  // Offset-binary level so silence (0x0000) maps to 50% duty.
  assign level = {~sample[15], sample[14:8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < level);
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: doc/sample_fetch.md
# sample_fetch

Streams a stored audio sample buffer out of external cellular RAM toward the synthesizer output path. Sits directly downstream of the RAM controller: it issues single-word read requests, buffers returned 16-bit words in a small FIFO, and releases one sample per sample-rate tick. An optional PWM stage drives a 1-bit audio pin directly.

## Interface
Parameters:
- ADDR_W, 26: word address width toward the RAM controller.
- FIFO_DEPTH, 8: sample FIFO entries, power of two, at least 2.
- CLK_DIV, 2268: clocks per sample tick (100 MHz / 44.1 kHz); at least FIFO_DEPTH+4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin playback (honoured in IDLE only).
- stop  in  1  one-cycle pulse; abort playback.
- loop  in  1  sampled at start; replay the buffer on reaching its end.
- base_addr  in  ADDR_W  first word address, sampled at start.
- length  in  ADDR_W  word count, sampled at start; 0 means ignore start.
- rd_req  out  1  read request to the RAM controller.
- rd_addr  out  ADDR_W  read address; stable while rd_req is high.
- rd_ack  in  1  one-cycle pulse; rd_data valid in the same cycle.
- rd_data  in  16  read word.
- sample  out  16  current sample, two's complement.
- sample_valid  out  1  one-cycle pulse when sample updates.
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  sticky; a tick found the FIFO empty during playback.
- pwm_out  out  1  PWM audio (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, DRAIN, ABORT.
- IDLE: on start with length != 0, latch addr <= base_addr, remaining <= length, loop flag; clear underrun, flush FIFO, zero the tick divider; go to REQ. A start with length == 0 is ignored.
- REQ: when FIFO count < FIFO_DEPTH, assert rd_req with rd_addr = addr and go to WAIT. Otherwise hold.
- WAIT: hold rd_req and rd_addr until rd_ack. On rd_ack, push rd_data, increment addr (wraps modulo 2^ADDR_W), and decrement remaining. If remaining was 1: with loop set, reload addr/remaining from the latched base/length and go to REQ; otherwise go to DRAIN. If remaining was greater than 1, go to REQ.
- At most one read is outstanding, so a push can never overflow the FIFO.
- DRAIN: go to IDLE on the cycle the FIFO becomes empty.
- stop: in WAIT, go to ABORT, which waits for rd_ack, discards the data, then goes to IDLE. From REQ or DRAIN, go to IDLE immediately. Entering IDLE flushes the FIFO. stop in IDLE has no effect. If stop and rd_ack arrive in the same cycle in WAIT, discard the word and go to IDLE.
- Tick divider: counts 0..CLK_DIV-1 while busy and holds 0 in IDLE. A tick fires at the terminal count.
  - Tick with FIFO non-empty: pop the FIFO into sample.
  - Tick with FIFO empty in REQ or WAIT: set underrun; sample holds its value; no sample_valid.
- A push and a pop in the same cycle leave the FIFO count unchanged.
- Reset values: rd_req 0, rd_addr 0, sample 0, sample_valid 0, busy 0, underrun 0, pwm_out 0, state IDLE, FIFO empty.

## Timing
- rd_req rises in the cycle after entry to REQ with space available; start to first rd_req is 2 cycles.
- rd_req falls in the cycle after rd_ack is sampled. Back-to-back requests are spaced by at least 2 cycles.
- sample and sample_valid are registered: both update in the cycle after the tick.
- The first tick occurs CLK_DIV cycles after start is sampled.
- busy falls in the cycle after the FIFO empties in DRAIN, or the cycle after stop/ABORT completes.
- Reset asserted mid-transfer returns every output to its reset value asynchronously. The outstanding controller read is not tracked.

## Configuration
- SAMPLE_FETCH_PWM_EN defined:
  - pwm_out is driven by an 8-bit free-running counter.
  - It is compared against level = sample[15:8] with the MSB inverted (offset binary).
  - pwm_out = (counter < level), registered.
- SAMPLE_FETCH_PWM_EN undefined: no PWM logic; pwm_out is tied to 0.

## Test plan
- Reset then idle: hold rst = 0 for 5 cycles, release -> all outputs 0, busy 0; start with length = 0 -> busy stays 0.
- Single pass: base_addr = 0x100, length = 4, loop = 0, ack 3 cycles after each rd_req with data 0x1111..0x4444 -> rd_addr 0x100..0x103 in order; sample_valid pulses at ticks 1-4 carrying 0x1111..0x4444; busy falls after the 4th pop.
- Loop and address wrap: base_addr = 2^ADDR_W-2, length = 3, loop = 1 -> rd_addr sequence 0x3FFFFFE, 0x3FFFFFF, 0x0, 0x3FFFFFE, ...
- Backpressure: FIFO_DEPTH = 8, CLK_DIV = 20, immediate acks -> rd_req stops after 8 outstanding entries, resumes within 2 cycles of each pop; underrun stays 0.
- Underrun: ack delayed 50 cycles with CLK_DIV = 20 -> underrun set at the first tick; sample holds 0; no sample_valid; underrun clears on the next start.
- Abort: stop while in WAIT, rd_ack 4 cycles later -> rd_req holds until the ack, the word is not output, busy falls the cycle after the ack, FIFO is empty.
